sseg_mux_param: RTL and testbench
=================================

Name: sseg_mux_param

Overview:
Parametrised successor to the team's fixed 4-digit seven-segment time multiplexer. It scans NUM_DIGITS hex digits onto a common-anode display with a programmable refresh rate, per-digit enables, leading-zero blanking and PWM brightness. Display contents are sampled once per frame so a digit cannot change mid-scan. The block sits between user logic (counters, stopwatch, UART debug) and the board's anode and segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 1..16.
REFRESH_DIV, 100000, clock cycles per digit slot; minimum 2.
BRIGHT_BITS, 4, width of the brightness control and PWM counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
hex_in  input  4*NUM_DIGITS  digit i = hex_in[4i+3:4i]; digit 0 is rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high
digit_en  input  NUM_DIGITS  1 = digit may light; 0 = anode held off for its slot
blank_lz  input  1  1 = suppress leading zeros
brightness  input  BRIGHT_BITS  0 = dark; all-ones = full on
an  output  NUM_DIGITS  anode selects, active-low, registered
sseg  output  8  {dp, g, f, e, d, c, b, a}, all active-low, registered
frame_tick  output  1  one-cycle pulse when digit index wraps to 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Values while rst is high (take effect at the next clk edge):
  - prescaler, digit index, PWM counter and snapshot registers = 0
  - an = all ones, sseg = 8'hFF, frame_tick = 0
  - Reset mid-scan aborts the current slot. After release, scanning restarts at digit 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count, the digit index increments; NUM_DIGITS-1 wraps to 0.
  - Index width is max(1, $clog2(NUM_DIGITS)). With NUM_DIGITS=1 the index stays at 0.
- Frame snapshot:
  - hex_in, dp_in and digit_en are registered on the same edge the index wraps to 0.
  - Also captured on the first edge after reset release.
  - Input changes are therefore never visible mid-frame.
- Frame tick: frame_tick = 1 for exactly the cycle in which the index equals 0 and the prescaler equals 0.
- Leading-zero blanking, evaluated on the snapshot:
  - Digit i is blank when blank_lz=1 and, for every j >= i, hex_j==0 and dp_j==0.
  - Digit 0 is never blanked.
  - A blank digit drives segments 7'h7F, and its anode stays asserted.
- Brightness:
  - A free-running BRIGHT_BITS counter pwm_cnt increments every clk.
  - lit = (brightness == all ones) or (pwm_cnt < brightness).
  - brightness=0 means never lit.
- Anode output: an[idx] = ~(lit & digit_en_snap[idx]); all other anodes = 1.
- Segment output: sseg = {~dp_snap[idx], seg7(hex_snap[idx]) or 7'h7F if blank}, using the standard active-low 0-F table.
  - Examples: 0=1000000, 8=0000000, F=0001110.
- Latency: an and sseg are registered, one clk after idx / pwm_cnt change. There are no combinational paths from inputs to outputs.
- Simultaneous events: an index wrap coinciding with an input change uses the old value for the current edge's output. The new value appears from the following frame.
- Parameter misuse: illegal parameter values are a lint/elaboration error, via an assertion on NUM_DIGITS and REFRESH_DIV.

Decomposition:
- Package sseg_pkg:
  - SEG_BLANK = 7'h7F
  - typedef seg7_t (logic [6:0])
  - function hex_to_seg7 (16-entry active-low table)
- One sub-module, sseg_lz_blank: combinational; computes the per-digit blank vector from the snapshot and blank_lz.
- Top holds prescaler, index, PWM counter, snapshot and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BRIGHT_BITS=4.
- Reset check: hold rst 3 cycles -> an=4'b1111, sseg=8'hFF, frame_tick=0. After release, digit 0 is selected (an=4'b1110) within 2 cycles.
- Full-brightness scan: hex_in=16'h4321, dp_in=4'b0100, digit_en=4'hF, brightness=4'hF.
  - Slot order is an=1110/1101/1011/0111, each 4 cycles.
  - sseg = 8'hF9, 8'hA4, 8'h30, 8'h99 (digit 2 has dp low).
  - frame_tick pulses every 16 cycles.
- Leading-zero blanking: hex_in=16'h0050, dp_in=0, blank_lz=1 -> digits 3 and 2 show sseg=8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0. With hex_in=16'h0000, digit 0 shows 8'hC0.
- Mid-frame change: change hex_in while digit 1 is being driven -> current frame outputs are unchanged. The new value appears only after the next frame_tick.
- Dimming: brightness=4 -> within each 16-cycle pwm window, the selected anode is low for exactly 4 cycles. brightness=0 -> an stays 4'b1111. digit_en=4'b1011 -> an[2] never goes low.
- Reset mid-scan: assert rst during slot 2 for 1 cycle -> next outputs are the reset values, then the scan restarts at digit 0 with a fresh snapshot.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and the hex-to-segment decode for the seven-segment multiplexer.
// Segment vectors are {g, f, e, d, c, b, a}, active-low, common-anode display.
package sseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  function automatic seg7_t hex_to_seg7(input logic [3:0] hex);
    hex_to_seg7 = SEG_BLANK;
    case (hex)
      4'h0: hex_to_seg7 = 7'b1000000;
      4'h1: hex_to_seg7 = 7'b1111001;
      4'h2: hex_to_seg7 = 7'b0100100;
      4'h3: hex_to_seg7 = 7'b0110000;
      4'h4: hex_to_seg7 = 7'b0011001;
      4'h5: hex_to_seg7 = 7'b0010010;
      4'h6: hex_to_seg7 = 7'b0000010;
      4'h7: hex_to_seg7 = 7'b1111000;
      4'h8: hex_to_seg7 = 7'b0000000;
      4'h9: hex_to_seg7 = 7'b0010000;
      4'hA: hex_to_seg7 = 7'b0001000;
      4'hB: hex_to_seg7 = 7'b0000011;
      4'hC: hex_to_seg7 = 7'b1000110;
      4'hD: hex_to_seg7 = 7'b0100001;
      4'hE: hex_to_seg7 = 7'b0000110;
      4'hF: hex_to_seg7 = 7'b0001110;
    endcase
  endfunction

endpackage

// File: rtl/sseg_lz_blank.sv
// Leading-zero blanking: a digit goes dark when it and every more-significant
// digit hold zero with no decimal point. Digit 0 always shows.
module sseg_lz_blank #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] hex,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   blank
);

  localparam logic [NUM_DIGITS-1:0] DIGIT0 = NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_run;

  // NOTE: every combinational output gets a default before the loop so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (hex[4*i +: 4] == 4'h0) & ~dp[i];
      zero_from[i] = zero_run;
    end
  end

  assign blank = zero_from & ~DIGIT0 & {NUM_DIGITS{blank_lz}};

endmodule

// File: rtl/sseg_mux_param.sv
// Time-multiplexed driver for NUM_DIGITS common-anode hex digits with frame
// snapshot, per-digit enable, leading-zero blanking and PWM brightness.
module sseg_mux_param
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_tick
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("sseg_mux_param: NUM_DIGITS must be within 1..16");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("sseg_mux_param: REFRESH_DIV must be at least 2");
  end

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

  logic [PRE_W-1:0]        pre,  pre_nxt;
  logic [IDX_W-1:0]        idx,  idx_nxt;
  logic [BRIGHT_BITS-1:0]  pwm_cnt;
  logic [4*NUM_DIGITS-1:0] hex_snap;
  logic [NUM_DIGITS-1:0]   dp_snap, en_snap, blank;
  logic                    snap_pending;
  logic                    pre_tc, idx_wrap, lit;
  seg7_t                   cur_seg;
  logic [NUM_DIGITS-1:0]   an_nxt;

  assign pre_tc   = (pre == LAST_PRE);
  assign idx_wrap = pre_tc && (idx == LAST_IDX);
  assign lit      = (brightness == '1) || (pwm_cnt < brightness);

  sseg_lz_blank #(.NUM_DIGITS(NUM_DIGITS)) u_lz_blank (
    .hex      (hex_snap),
    .dp       (dp_snap),
    .blank_lz (blank_lz),
    .blank    (blank)
  );

  always_comb begin
    pre_nxt = pre_tc ? '0 : pre + 1'b1;
    idx_nxt = idx;
    if (idx_wrap)    idx_nxt = '0;
    else if (pre_tc) idx_nxt = idx + 1'b1;

    cur_seg = blank[idx] ? SEG_BLANK : hex_to_seg7(hex_snap[4*idx +: 4]);
    an_nxt  = '1;
    if (lit && en_snap[idx]) an_nxt[idx] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre          <= '0;
      idx          <= '0;
      pwm_cnt      <= '0;
      hex_snap     <= '0;
      dp_snap      <= '0;
      en_snap      <= '0;
      snap_pending <= 1'b1;
      an           <= '1;
      sseg         <= 8'hFF;
      frame_tick   <= 1'b0;
    end else begin
      pre          <= pre_nxt;
      idx          <= idx_nxt;
      pwm_cnt      <= pwm_cnt + 1'b1;
      frame_tick   <= (idx_nxt == '0) && (pre_nxt == '0);
      an           <= an_nxt;
      sseg         <= {~dp_snap[idx], cur_seg};
      snap_pending <= 1'b0;
      // Inputs are frozen for a whole frame; the first edge after reset also loads them.
      if (idx_wrap || snap_pending) begin
        hex_snap <= hex_in;
        dp_snap  <= dp_in;
        en_snap  <= digit_en;
      end
    end
  end

endmodule

// File: tb/tb_sseg_mux_param.sv
// Scoreboard bench for sseg_mux_param (4 digits, 4-cycle slots, 4-bit PWM):
// stimulus queues per-cycle expectations, a negedge monitor pops and compares.
module tb_sseg_mux_param;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*N-1:0]  hex_in = '0;
  logic [N-1:0]    dp_in = '0;
  logic [N-1:0]    digit_en = '0;
  logic            blank_lz = 1'b0;
  logic [BB-1:0]   brightness = '0;
  logic [N-1:0]    an;
  logic [7:0]      sseg;
  logic            frame_tick;

  always #5 clk = ~clk;

  sseg_mux_param #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BRIGHT_BITS(BB)) dut (
    .clk        (clk),
    .rst        (rst),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .brightness (brightness),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       ft;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation that falls due on this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, " an"},   32'(an),         32'(mon_e.an));
      check({mon_e.tag, " sseg"}, 32'(sseg),       32'(mon_e.sseg));
      check({mon_e.tag, " tick"}, 32'(frame_tick), 32'(mon_e.ft));
    end
  end

  task automatic push(input int c, input logic [3:0] a, input logic [7:0] s,
                      input logic f, input string t);
    exp_t e;
    e.cyc = c; e.an = a; e.sseg = s; e.ft = f; e.tag = t;
    sb.push_back(e);
  endtask

  // Called at a negedge: holds rst for n edges, then releases; base + k is the
  // cycle following the k-th edge after release.
  task automatic do_reset(input int n);
    int c0;
    rst = 1'b1;
    c0  = cyc;
    for (int i = 1; i <= n; i++) push(c0 + i, 4'hF, 8'hFF, 1'b0, "reset");
    repeat (n) @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  // Expected outputs after edges k_lo..k_hi since release. The first edge still
  // shows the cleared snapshot; slot d covers pwm values 4d..4d+3 of each frame.
  // tbl holds the hand-decoded sseg bytes {d3, d2, d1, d0}.
  task automatic push_span(input int k_lo, input int k_hi, input logic [31:0] tbl,
                           input logic [3:0] en, input logic [3:0] br, input string tag);
    int         d, p;
    logic       lit;
    logic [3:0] a;
    for (int k = k_lo; k <= k_hi; k++) begin
      if (k == 1) begin
        push(base + k, 4'hF, 8'hC0, 1'b0, $sformatf("%s k=%0d", tag, k));
      end else begin
        d   = ((k - 1) / 4) % 4;
        p   = (k - 1) % 16;
        lit = (br == 4'hF) || (p < int'(br));
        a   = (lit && en[d]) ? ~(4'b0001 << d) : 4'hF;
        push(base + k, a, tbl[8*d +: 8], (k % 16) == 0, $sformatf("%s k=%0d", tag, k));
      end
    end
  endtask

  task automatic scan(input string tag, input logic [15:0] h, input logic [3:0] dp,
                      input logic [3:0] en, input logic lz, input logic [3:0] br,
                      input logic [31:0] tbl, input int frames);
    hex_in = h; dp_in = dp; digit_en = en; blank_lz = lz; brightness = br;
    do_reset(3);
    push_span(1, 16 * frames, tbl, en, br, tag);
    repeat (16 * frames) @(negedge clk);
  endtask

  localparam logic [31:0] TBL_4321 = 32'h9930_A4F9;
  localparam logic [31:0] TBL_8765 = 32'h80F8_8292;

  initial begin
    @(negedge clk);
    scan("full",      16'h4321, 4'b0100, 4'hF,    1'b0, 4'hF, TBL_4321,       2);
    scan("lz 0050",   16'h0050, 4'b0000, 4'hF,    1'b1, 4'hF, 32'hFFFF_92C0,  1);
    scan("lz 0000",   16'h0000, 4'b0000, 4'hF,    1'b1, 4'hF, 32'hFFFF_FFC0,  1);
    scan("lz dp3",    16'h0000, 4'b1000, 4'hF,    1'b1, 4'hF, 32'h40C0_C0C0,  1);
    scan("no lz",     16'h0050, 4'b0000, 4'hF,    1'b0, 4'hF, 32'hC0C0_92C0,  1);
    scan("bright4",   16'h4321, 4'b0100, 4'hF,    1'b0, 4'h4, TBL_4321,       2);
    scan("bright6",   16'h4321, 4'b0100, 4'hF,    1'b0, 4'h6, TBL_4321,       1);
    scan("bright0",   16'h4321, 4'b0100, 4'hF,    1'b0, 4'h0, TBL_4321,       1);
    scan("en1011",    16'h4321, 4'b0100, 4'b1011, 1'b0, 4'hF, TBL_4321,       2);

    // Mid-frame change while digit 1 is on: new data only from the third frame.
    hex_in = 16'h4321; dp_in = 4'b0100; digit_en = 4'hF; blank_lz = 1'b0; brightness = 4'hF;
    do_reset(3);
    push_span(1, 32, TBL_4321, 4'hF, 4'hF, "midframe old");
    push_span(33, 48, TBL_8765, 4'hF, 4'hF, "midframe new");
    repeat (21) @(negedge clk);
    hex_in = 16'h8765; dp_in = 4'b0000;
    repeat (27) @(negedge clk);

    // One-cycle reset during slot 2, then a fresh scan from digit 0.
    hex_in = 16'h4321; dp_in = 4'b0100;
    do_reset(3);
    push_span(1, 9, TBL_4321, 4'hF, 4'hF, "preabort");
    repeat (9) @(negedge clk);
    hex_in = 16'h8765; dp_in = 4'b0000;
    do_reset(1);
    push_span(1, 16, TBL_8765, 4'hF, 4'hF, "restart");
    repeat (16) @(negedge clk);

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
